// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer datapath blocks:
// serializer state encoding, default element width and index-width helper.
package nn_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } ser_state_e;

    localparam int DATA_WIDTH_DEF = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum over one streamed frame; publishes the winning
// index as a one-cycle pulse after the final element is accepted.
module argmax_tracker
    import nn_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH_DEF,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_accept,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [IDX_W-1:0]  o_class_idx,
    output logic              o_class_valid
);

    logic signed [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]         r_max_idx;
    logic [IDX_W-1:0]         r_class_idx;
    logic                     r_class_valid;
    logic                     w_take;
    logic [IDX_W-1:0]         w_win_idx;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        w_take = i_first || ($signed(i_data) > r_max);
        if (w_take) begin
            w_win_idx = i_idx;
        end else begin
            w_win_idx = r_max_idx;
        end
    end

    // Maximum tracking and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max         <= '0;
            r_max_idx     <= '0;
            r_class_idx   <= '0;
            r_class_valid <= 1'b0;
        end else begin
            r_class_valid <= i_accept && i_last;
            if (i_accept) begin
                if (w_take) begin
                    r_max     <= i_data;
                    r_max_idx <= i_idx;
                end
                if (i_last) begin
                    r_class_idx <= w_win_idx;
                end
            end
        end
    end

    assign o_class_idx   = r_class_idx;
    assign o_class_valid = r_class_valid;

endmodule

// File: rtl/layer_stream_serializer.sv
// Gathers per-neuron results of one layer and replays them as a serial
// valid/ready stream. Optional argmax output enabled by LAYER_SER_ARGMAX_EN.
module layer_stream_serializer
    import nn_pkg::*;
#(
    parameter int  NUM_NEURONS = 10,
    parameter int  data_width  = DATA_WIDTH_DEF,
    localparam int IDX_W       = idx_width(NUM_NEURONS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_NEURONS-1:0][data_width-1:0] layer_in,
    input  logic [NUM_NEURONS-1:0]                 layer_valid,
    output logic [data_width-1:0]                  out_data,
    output logic [IDX_W-1:0]                       out_idx,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic                                   overflow,
    output logic [IDX_W-1:0]                       class_idx,
    output logic                                   class_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    ser_state_e                             r_state, w_state_nxt;
    logic [NUM_NEURONS-1:0]                 r_got;
    logic [NUM_NEURONS-1:0][data_width-1:0] r_buf, w_buf_nxt;
    logic [data_width-1:0]                  r_out_data, w_data_nxt;
    logic [IDX_W-1:0]                       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                                   r_out_valid, w_valid_nxt;
    logic                                   r_out_last, w_last_nxt;
    logic                                   r_overflow;
    logic                                   w_hs;
    logic                                   w_all_got;

    assign w_hs      = r_out_valid && out_ready;
    assign w_all_got = &(r_got | layer_valid);
    assign w_cnt_inc = r_cnt + IDX_W'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_all_got) w_state_nxt = SEND;    else w_state_nxt = COLLECT;
            SEND:    if (w_hs && r_out_last) w_state_nxt = COLLECT; else w_state_nxt = SEND;
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Buffer capture is only open while collecting; the completing cycle's
    // data must also feed element 0 directly.
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if ((r_state == COLLECT) && layer_valid[i]) begin
                w_buf_nxt[i] = layer_in[i];
            end else begin
                w_buf_nxt[i] = r_buf[i];
            end
        end
    end

    // Next values of the registered stream outputs.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_out_data;
        w_valid_nxt = r_out_valid;
        w_last_nxt  = r_out_last;
        case (r_state)
            COLLECT: begin
                if (w_all_got) begin
                    w_cnt_nxt   = '0;
                    w_data_nxt  = w_buf_nxt[0];
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                end
            end
            SEND: begin
                if (w_hs && r_out_last) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                end else if (w_hs) begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_data_nxt = r_buf[w_cnt_inc];
                    w_last_nxt = (w_cnt_inc == LAST_IDX);
                end else begin
                    w_valid_nxt = r_out_valid;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_got       <= '0;
            r_buf       <= '0;
            r_out_data  <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_buf       <= w_buf_nxt;
            r_out_data  <= w_data_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            if (r_state == COLLECT) begin
                r_got <= w_all_got ? '0 : (r_got | layer_valid);
            end else begin
                r_overflow <= r_overflow | (|layer_valid);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_idx   = r_cnt;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign overflow  = r_overflow;

`ifdef LAYER_SER_ARGMAX_EN
    argmax_tracker #(
        .DATA_W (data_width),
        .IDX_W  (IDX_W)
    ) u_argmax (
        .clk           (clk),
        .rst           (rst),
        .i_accept      (w_hs),
        .i_first       (r_cnt == '0),
        .i_last        (r_out_last),
        .i_data        (r_out_data),
        .i_idx         (r_cnt),
        .o_class_idx   (class_idx),
        .o_class_valid (class_valid)
    );
`else
    assign class_idx   = '0;
    assign class_valid = 1'b0;
`endif

endmodule

// File: doc/layer_stream_serializer.md
# layer_stream_serializer

Collects the parallel per-neuron results of one fully connected layer and re-emits them as a single serial stream, one element per cycle, for the next layer's shared `in` bus. Neurons within a layer finish independently, so the block gathers each neuron's result on its own `o_valid` pulse. Once every neuron has reported, it streams element 0 through NUM_NEURONS-1 under a valid/ready handshake. It sits between layer N outputs and layer N+1 inputs.

## Interface
- NUM_NEURONS, 10, neurons in the producing layer (>= 2)
- data_width, 16, width of each element (signed two's complement)
- IDX_W, $clog2(NUM_NEURONS), index width (derived, not overridden)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- layer_in  in  NUM_NEURONS x data_width  per-neuron results, packed [NUM_NEURONS-1:0][data_width-1:0]
- layer_valid  in  NUM_NEURONS  per-neuron one-cycle valid pulses
- out_data  out  data_width  current stream element
- out_idx  out  IDX_W  neuron index of out_data
- out_valid  out  1  element presented
- out_ready  in  1  consumer accepts the element
- out_last  out  1  high with the final element (idx NUM_NEURONS-1)
- overflow  out  1  sticky; a valid pulse arrived while not collecting
- class_idx  out  IDX_W  argmax result (ARGMAX build only, else tied 0)
- class_valid  out  1  one-cycle pulse with class_idx (ARGMAX build only, else 0)

## Operation
- States: COLLECT, SEND.
- Reset: state COLLECT, got mask 0, element buffer 0, out_valid 0, out_last 0, out_data 0, out_idx 0, overflow 0, class_idx 0, class_valid 0.
- COLLECT:
  - For each i with layer_valid[i]=1, capture layer_in[i] into buf[i] and set got[i].
  - Several bits may pulse in the same cycle; all are captured.
  - A repeat pulse on an already-got bit overwrites buf[i].
- COLLECT -> SEND: when (got | layer_valid) is all-ones, including the cycle of the last pulse. On entry: send counter = 0, got cleared.
- SEND:
  - out_valid=1, out_data=buf[cnt], out_idx=cnt, out_last=(cnt==NUM_NEURONS-1).
  - On out_valid & out_ready: cnt increments.
  - Handshake with out_last -> COLLECT.
- out_data and out_idx hold stable while out_valid & !out_ready.
- Any layer_valid bit high in SEND sets overflow. The data is dropped and buf is not modified. overflow clears only on rst.
- Reset asserted mid-SEND aborts the frame immediately; no partial frame resumes.

## Timing
- All outputs registered.
- Last layer_valid pulse at cycle T -> out_valid=1 at T+1.
- With out_ready held high: elements at T+1 .. T+NUM_NEURONS, out_last at T+NUM_NEURONS.
- First layer_valid may be accepted at T+NUM_NEURONS+1 (cycle after last handshake). A pulse in the last-handshake cycle itself counts as overflow.
- Throughput: one element per cycle; a frame takes NUM_NEURONS + 1 cycles minimum, back to back.
- class_valid pulses the cycle after the out_last handshake.

## Configuration
- LAYER_SER_ARGMAX_EN defined:
  - Running signed maximum updated on each accepted stream element.
  - Reset to element 0 on its handshake.
  - Strictly greater replaces, so ties resolve to the lowest index.
  - class_idx registered and held until the next class_valid; class_valid pulses once per frame.
- Undefined: no comparator logic; class_idx=0 and class_valid=0 constantly.

## Structure
- Shared package `nn_pkg`:
  - State enum {COLLECT, SEND}.
  - Default data_width.
  - Index-width helper function.
- Natural sub-module: `argmax_tracker`, the running signed max and index. It is instantiated only under LAYER_SER_ARGMAX_EN.

## Test plan
All scenarios use NUM_NEURONS=4, data_width=16.
- Staggered completion: layer_valid bits 2,0,3,1 on consecutive cycles with values 0x0011, 0x0022, 0x0033, 0x0044 for idx 0..3; out_ready=1 -> stream 0x0011, 0x0022, 0x0033, 0x0044 with idx 0..3. First out_valid one cycle after bit 1 pulses; out_last on idx 3.
- Simultaneous completion: all four bits in one cycle -> out_valid next cycle; four consecutive elements.
- Backpressure: out_ready low for 3 cycles on idx 1 -> out_data/out_idx held stable, no element skipped or duplicated.
- Overflow: layer_valid[0] pulses during SEND -> overflow=1 and stays high; streamed data unchanged; next frame still collects correctly.
- Reset mid-stream: rst after idx 1 is accepted -> all outputs at reset values at once. A fresh frame then streams from idx 0.
- Argmax (macro on): values 0xFFF0, 0x0005, 0x0005, 0x0003 -> class_idx=1, class_valid one cycle after out_last handshake. Macro off -> class_valid never asserts.
